spart_driver: RTL

Bus-master counterpart of the SPART: owns the `iocs/iorw/ioaddr/databus` side of the SPART register interface on behalf of on-chip logic. After reset it programs the baud divisor selected by `br_cfg`, then services the SPART by reading received bytes when `rda` is high and writing queued bytes when `tbr` is high. It exposes a simple valid/ready byte interface to user logic and sits beside `spart` in the top level.

---
 rtl/spart_driver_pkg.sv | 31 +++
 rtl/spart_driver_if.sv | 27 ++
 rtl/spart_driver.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/spart_driver_pkg.sv
// spart_pkg: shared definitions for the SPART bus-master driver.
//   ADDR_*      SPART register addresses on ioaddr
//   drv_state_t driver FSM states
//   divisor()   16-bit baud divisor for a given clock and br_cfg code
package spart_pkg;

    localparam logic [1:0] ADDR_BUF    = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DB_LO  = 2'b10;
    localparam logic [1:0] ADDR_DB_HI  = 2'b11;

    typedef enum logic [2:0] {
        CFG_LO,
        CFG_HI,
        IDLE,
        RD_RX,
        WR_TX
    } drv_state_t;

    // clk_hz/(16*baud) - 1, with the quotient rounded to nearest so that
    // e.g. 100 MHz @ 38400 gives 162 rather than the truncated 161.
    function automatic logic [15:0] divisor(input int unsigned clk_hz,
                                            input logic [1:0]  br_cfg);
        int unsigned baud;
        int unsigned q;
        baud = 32'd4800 << br_cfg;
        q    = (clk_hz + 32'd8 * baud) / (32'd16 * baud) - 32'd1;
        return q[15:0];
    endfunction

endpackage

// File: rtl/spart_driver_if.sv
// spart_driver_if: SPART control/status handshake between the driver and
// the SPART register block.
//   iocs   chip select (one cycle per access)
//   iorw   1 = read, 0 = write
//   ioaddr register address (see spart_pkg ADDR_*)
//   rda    receive data available (from SPART)
//   tbr    transmit buffer ready (from SPART)
// The 8-bit bidirectional databus stays a plain inout port on the modules.
interface spart_driver_if;

    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       rda;
    logic       tbr;

    modport master (
        output iocs, iorw, ioaddr,
        input  rda, tbr
    );

    modport slave (
        input  iocs, iorw, ioaddr,
        output rda, tbr
    );

endinterface

// File: rtl/spart_driver.sv
// spart_driver: bus master for the SPART register interface.
// After reset it writes the baud divisor selected by br_cfg, then reads a
// received byte whenever rda is high and writes the queued byte whenever
// tbr is high and a byte is pending. User logic sees a one-entry
// valid/ready transmit path and a one-cycle rx_valid pulse.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous, active-low reset
//   br_cfg    baud select 00=4800 01=9600 10=19200 11=38400
//   sbus      spart_driver_if.master (iocs, iorw, ioaddr, rda, tbr)
//   databus   SPART data bus, driven only during write cycles
//   tx_data   byte to send          tx_valid  tx_data valid
//   tx_ready  holding register free
//   rx_data   last received byte    rx_valid  one-cycle pulse, new rx_data
//
// Build option: define SPART_DRV_ECHO_EN to echo every received byte back
// into the holding register (if it is empty).
module spart_driver
    import spart_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           br_cfg,
    spart_driver_if.master       sbus,
    inout  wire  [7:0]           databus,
    input  logic [7:0]           tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [7:0]           rx_data,
    output logic                 rx_valid
);

    localparam logic [15:0] DIV_0 = divisor(CLK_HZ, 2'd0);
    localparam logic [15:0] DIV_1 = divisor(CLK_HZ, 2'd1);
    localparam logic [15:0] DIV_2 = divisor(CLK_HZ, 2'd2);
    localparam logic [15:0] DIV_3 = divisor(CLK_HZ, 2'd3);

    drv_state_t  state, state_nx;
    logic        run;
    logic [1:0]  br_sync_p0, br_sync_p1;
    logic [1:0]  br_cur;
    logic [15:0] div_cur;
    logic        pending;
    logic [7:0]  hold;
    logic        load_tx;
    logic        load_echo;
    logic        load_cfg;
    logic        iocs, iorw;
    logic [1:0]  ioaddr;
    logic [7:0]  wr_data;

    // Synchronizer stage boundary: br_cfg -> br_sync_p0 -> br_sync_p1.
    // Left unreset so the clock running during reset fills it with the
    // live br_cfg and the first divisor written is the requested one.
    always_ff @(posedge clk) begin
        br_sync_p0 <= br_cfg;
        br_sync_p1 <= br_sync_p0;
    end

    // run is low only while in reset and for the edge that leaves it; it
    // keeps the bus quiet during reset while state already sits in CFG_LO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= CFG_LO;
            run   <= 1'b0;
        end else begin
            state <= state_nx;
            run   <= 1'b1;
        end
    end

    assign load_cfg = !run || (state == IDLE && state_nx == CFG_LO);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_cur <= 2'b00;
        end else if (load_cfg) begin
            br_cur <= br_sync_p1;
        end
    end

    always_comb begin
        div_cur = DIV_0;
        case (br_cur)
            2'd0:    div_cur = DIV_0;
            2'd1:    div_cur = DIV_1;
            2'd2:    div_cur = DIV_2;
            default: div_cur = DIV_3;
        endcase
    end

    always_comb begin
        state_nx = state;
        iocs     = 1'b0;
        iorw     = 1'b1;
        ioaddr   = ADDR_BUF;
        wr_data  = hold;
        case (state)
            CFG_LO: begin
                if (run) begin
                    iocs     = 1'b1;
                    iorw     = 1'b0;
                    ioaddr   = ADDR_DB_LO;
                    wr_data  = div_cur[7:0];
                    state_nx = CFG_HI;
                end
            end
            CFG_HI: begin
                iocs     = 1'b1;
                iorw     = 1'b0;
                ioaddr   = ADDR_DB_HI;
                wr_data  = div_cur[15:8];
                state_nx = IDLE;
            end
            IDLE: begin
                if (br_sync_p1 != br_cur) begin
                    state_nx = CFG_LO;
                end else if (sbus.rda) begin
                    state_nx = RD_RX;
                end else if (pending && sbus.tbr) begin
                    state_nx = WR_TX;
                end
            end
            RD_RX: begin
                iocs     = 1'b1;
                iorw     = 1'b1;
                ioaddr   = ADDR_BUF;
                state_nx = IDLE;
            end
            WR_TX: begin
                iocs     = 1'b1;
                iorw     = 1'b0;
                ioaddr   = ADDR_BUF;
                wr_data  = hold;
                state_nx = IDLE;
            end
            default: state_nx = CFG_LO;
        endcase
    end

    assign sbus.iocs   = iocs;
    assign sbus.iorw   = iorw;
    assign sbus.ioaddr = ioaddr;
    assign databus     = (iocs && !iorw) ? wr_data : 8'bz;

`ifdef SPART_DRV_ECHO_EN
    // The echo claims the empty holding register at the end of RD_RX, so
    // user data is not offered during that cycle.
    assign tx_ready  = !pending && (state == IDLE || state == WR_TX);
    assign load_echo = (state == RD_RX) && !pending;
`else
    assign tx_ready  = !pending && (state == IDLE || state == RD_RX || state == WR_TX);
    assign load_echo = 1'b0;
`endif
    assign load_tx = tx_valid && tx_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= 1'b0;
        end else if (state == WR_TX) begin
            pending <= 1'b0;
        end else if (load_echo || load_tx) begin
            pending <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (load_echo) begin
            hold <= databus;
        end else if (load_tx) begin
            hold <= tx_data;
        end
    end

    // Read stage boundary: databus captured at the edge ending RD_RX,
    // rx_valid flags it for the following cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= (state == RD_RX);
            if (state == RD_RX) begin
                rx_data <= databus;
            end
        end
    end

endmodule
